hex_display_ctrl: RTL and testbench
===================================

Name: hex_display_ctrl

Overview:
- Sequences the six seven-segment digit codes (5-bit: 0x0–0xF hex, 0x10–0x1D letters G H I L M N O P Q R S T U V, 0x1E blank, 0x1F dash) that feed the six seg7 decoder instances on HEX5..HEX0.
- Arbitrates between two display sources:
  - Score/lives readout, converted binary→BCD by a sequential double-dabble.
  - Scrolling status messages WIN / LOSE / GAME OVER, requested by the game FSM.
- Sits between the game-state logic and the seg7 decoders.

Parameters:
- SCORE_W, 14, score input width; values above 9999 display as 9999.
- TICK_DIV, 12500000, clk cycles per scroll step (≥2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- score  in  SCORE_W  binary score, sampled on score_load
- score_load  in  1  1-cycle pulse: convert and display score
- lives  in  4  lives count; values >9 display as 9
- msg_req  in  3  one-hot pulses: [2]=GAME OVER, [1]=LOSE, [0]=WIN
- msg_clear  in  1  pulse: leave message mode, return to score readout
- hex0..hex5  out  5 each  registered digit codes; hex5 is leftmost
- msg_active  out  1  high while in message mode
- busy  out  1  high while BCD conversion in progress

Behaviour:
- All outputs registered. Reset values (synchronous, active-high; applies mid-conversion or mid-scroll):
  - msg_active=0, busy=0.
  - hex5=0x0, hex4=0x1F.
  - hex3..hex0 show score 0. See Optional Feature for blanking.
  - Conversion state, pending flag, scroll position and tick counter cleared.
- Score-mode layout:
  - hex5 = min(lives,9).
  - hex4 = 0x1F (dash).
  - hex3..hex0 = BCD thousands..ones of the last converted score.
  - lives is applied on the next clock, no conversion needed.
- Converter FSM, states CONV_IDLE → CONV_SHIFT → CONV_DONE:
  - score_load in CONV_IDLE latches min(score,9999); busy=1 next cycle.
  - CONV_SHIFT: SCORE_W iterations of add-3-if-≥5 then shift, one per cycle.
  - CONV_DONE: one cycle. BCD is committed to the digit registers; busy falls next cycle.
  - Latency: digits update SCORE_W+2 cycles after score_load.
  - score_load while busy: the value is latched into a pending register and a pending flag is set. The last such load wins. The pending conversion starts the cycle after CONV_DONE; busy stays high throughout.
  - Conversion keeps running in message mode. Results update the stored digits only; they become visible on return to score mode.
- Message FSM, states SHOW_SCORE and SHOW_MSG:
  - Message strings (codes):
    - WIN = U U I N (0x1C 0x1C 0x12 0x15), L=4.
    - LOSE = L O S E (0x13 0x16 0x1A 0x0E), L=4.
    - GAME OVER = G A M E _ O V E R (0x10 0x0A 0x14 0x0E 0x1E 0x16 0x1D 0x0E 0x19), L=9.
  - Virtual string V = message followed by 6 blanks; period P = L+6.
  - At scroll position p: hex5..hex0 = V[p], V[(p+1) mod P], …, V[(p+5) mod P].
  - Tick counter counts 0..TICK_DIV-1. At terminal count: p ← (p+1) mod P, counter → 0. Scrolling repeats until cleared.
  - Entering SHOW_MSG sets p=0 and counter=0. The first frame, message left-aligned, appears the cycle after the request.
  - Simultaneous bits in msg_req: priority GAME OVER > LOSE > WIN.
  - Request in SHOW_MSG:
    - Strictly higher priority: replaces the message, p and counter reset.
    - Equal or lower priority: ignored.
  - msg_clear → SHOW_SCORE. Score layout appears the next cycle, with latest digits and lives.
  - msg_req and msg_clear in the same cycle: the request wins, msg_clear is ignored.
  - msg_clear in SHOW_SCORE: no effect.
- msg_active = (state == SHOW_MSG), registered with the hex outputs.

Optional Feature:
- Macro: HEX_LZB_EN.
- Defined: leading-zero blanking in score mode. Leading zero digits of hex3..hex1 show 0x1E; hex0 is always shown.
  - Reset: hex3..hex1 = 0x1E, hex0 = 0x0.
  - Score 42: 0x1E 0x1E 0x4 0x2.
- Undefined: all four score digits always shown.
  - Reset: hex3..hex0 = 0x0.
  - Score 42: 0x0 0x0 0x4 0x2.

Test Plan:
1. Reset, then score=1234 with score_load pulse → busy high for SCORE_W+1 cycles; hex3..hex0 = 1,2,3,4 exactly SCORE_W+2 cycles after the load; hex4=0x1F.
2. score=12000 loaded; lives=12 → hex3..hex0 = 9,9,9,9; hex5 = 0x9.
3. score_load 5 at cycle 0, then 77 at cycle 3 and 88 at cycle 4 (while busy) → 5 displayed, then 88 (no 77 frame); busy continuous until 88 is committed.
4. TICK_DIV=2, msg_req=3'b001 → frame 0 = 1C 1C 12 15 1E 1E; two cycles later = 1C 12 15 1E 1E 1E; p wraps after 10 steps back to frame 0.
5. In WIN: msg_req=3'b100 → GAME OVER frame 0 (10 0A 14 0E 1E 16); then msg_req=3'b010 → ignored, GAME OVER continues.
6. In message mode: msg_req and msg_clear in the same cycle → stays in message mode. Then msg_clear alone → score layout next cycle, msg_active=0. Reset asserted mid-scroll → reset values next cycle.

Source files
------------

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - digit-code sequencer for six seven-segment displays
//
// Chooses what the six seg7 decoders show: either the score/lives readout
// (binary score turned into BCD by a sequential double-dabble) or a
// scrolling status message (WIN / LOSE / GAME OVER).
//
// Digit codes (5 bit): 0x00-0x0F hex, 0x10-0x1D letters
// G H I L M N O P Q R S T U V, 0x1E blank, 0x1F dash.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   score       binary score, sampled on score_load (clamped to 9999)
//   score_load  1-cycle pulse: convert and display score
//   lives       lives count (clamped to 9 for display)
//   msg_req     one-hot pulses: [2]=GAME OVER, [1]=LOSE, [0]=WIN
//   msg_clear   pulse: return from message mode to score readout
//   hex0..hex5  registered digit codes, hex5 is leftmost
//   msg_active  high while in message mode
//   busy        high while a BCD conversion is in progress
//
// Optional feature macro: HEX_LZB_EN (leading-zero blanking of hex3..hex1
// in score mode).

module hex_display_ctrl #(
    parameter int SCORE_W  = 14,
    parameter int TICK_DIV = 12500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_load,
    input  logic [3:0]         lives,
    input  logic [2:0]         msg_req,
    input  logic               msg_clear,
    output logic [4:0]         hex0,
    output logic [4:0]         hex1,
    output logic [4:0]         hex2,
    output logic [4:0]         hex3,
    output logic [4:0]         hex4,
    output logic [4:0]         hex5,
    output logic               msg_active,
    output logic               busy
);

    localparam int IW = $clog2(SCORE_W + 1);
    localparam int TW = $clog2(TICK_DIV);

    localparam logic [4:0] C_BLANK = 5'h1E;
    localparam logic [4:0] C_DASH  = 5'h1F;

    // Message priority levels; 0 means "no request".
    localparam logic [1:0] LVL_WIN  = 2'd1;
    localparam logic [1:0] LVL_LOSE = 2'd2;
    localparam logic [1:0] LVL_GO   = 2'd3;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        for (int n = 0; n < 4; n++) begin
            r[n*4 +: 4] = (b[n*4 +: 4] >= 4'd5) ? b[n*4 +: 4] + 4'd3 : b[n*4 +: 4];
        end
        return r;
    endfunction

    function automatic logic [19:0] score_digits(input logic [3:0] d3, input logic [3:0] d2,
                                                 input logic [3:0] d1, input logic [3:0] d0);
        logic [4:0] c3, c2, c1;
        c3 = {1'b0, d3};
        c2 = {1'b0, d2};
        c1 = {1'b0, d1};
`ifdef HEX_LZB_EN
        // Blank a digit only if it and every digit to its left are zero.
        if (d3 == 4'd0) begin
            c3 = C_BLANK;
            if (d2 == 4'd0) begin
                c2 = C_BLANK;
                if (d1 == 4'd0) c1 = C_BLANK;
            end
        end
`endif
        return {c3, c2, c1, 1'b0, d0};
    endfunction

    function automatic logic [3:0] msg_period(input logic [1:0] lvl);
        return (lvl == LVL_GO) ? 4'd15 : 4'd10;
    endfunction

    // Character idx of the virtual string (message followed by blanks).
    function automatic logic [4:0] msg_char(input logic [1:0] lvl, input logic [4:0] idx);
        logic [4:0] c;
        c = C_BLANK;
        case (lvl)
            LVL_WIN: begin
                case (idx)
                    5'd0, 5'd1: c = 5'h1C;
                    5'd2:       c = 5'h12;
                    5'd3:       c = 5'h15;
                    default:    c = C_BLANK;
                endcase
            end
            LVL_LOSE: begin
                case (idx)
                    5'd0:    c = 5'h13;
                    5'd1:    c = 5'h16;
                    5'd2:    c = 5'h1A;
                    5'd3:    c = 5'h0E;
                    default: c = C_BLANK;
                endcase
            end
            LVL_GO: begin
                case (idx)
                    5'd0:    c = 5'h10;
                    5'd1:    c = 5'h0A;
                    5'd2:    c = 5'h14;
                    5'd3:    c = 5'h0E;
                    5'd5:    c = 5'h16;
                    5'd6:    c = 5'h1D;
                    5'd7:    c = 5'h0E;
                    5'd8:    c = 5'h19;
                    default: c = C_BLANK;
                endcase
            end
            default: c = C_BLANK;
        endcase
        return c;
    endfunction

    // Six-character window starting at position p, leftmost in the MSBs.
    function automatic logic [29:0] msg_frame(input logic [1:0] lvl, input logic [3:0] p);
        logic [29:0] f;
        logic [4:0]  idx;
        logic [4:0]  per;
        f   = '0;
        per = {1'b0, msg_period(lvl)};
        for (int k = 0; k < 6; k++) begin
            idx = {1'b0, p} + 5'(k);
            if (idx >= per) idx = idx - per;
            f[29 - 5*k -: 5] = msg_char(lvl, idx);
        end
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Binary -> BCD converter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {CONV_IDLE, CONV_SHIFT, CONV_DONE} conv_state_t;

    conv_state_t        conv_state;
    logic [SCORE_W-1:0] bin_sr;
    logic [15:0]        bcd_sr;
    logic [IW-1:0]      iter;
    logic               pend;
    logic [SCORE_W-1:0] pend_val;
    logic [3:0]         dig3, dig2, dig1, dig0;
    logic [SCORE_W-1:0] score_clamped;

    assign score_clamped = (32'(score) > 32'd9999) ? SCORE_W'(9999) : score;

    always_ff @(posedge clk) begin
        if (reset) begin
            conv_state <= CONV_IDLE;
            busy       <= 1'b0;
            pend       <= 1'b0;
            pend_val   <= '0;
            bin_sr     <= '0;
            bcd_sr     <= '0;
            iter       <= '0;
            dig3       <= 4'd0;
            dig2       <= 4'd0;
            dig1       <= 4'd0;
            dig0       <= 4'd0;
        end else begin
            case (conv_state)
                CONV_IDLE: begin
                    if (score_load) begin
                        bin_sr     <= score_clamped;
                        bcd_sr     <= '0;
                        iter       <= '0;
                        busy       <= 1'b1;
                        conv_state <= CONV_SHIFT;
                    end
                end
                CONV_SHIFT: begin
                    if (score_load) begin
                        pend     <= 1'b1;
                        pend_val <= score_clamped;
                    end
                    {bcd_sr, bin_sr} <= {bcd_adjust(bcd_sr), bin_sr} << 1;
                    iter <= iter + 1'b1;
                    if (iter == IW'(SCORE_W - 1)) conv_state <= CONV_DONE;
                end
                CONV_DONE: begin
                    dig3 <= bcd_sr[15:12];
                    dig2 <= bcd_sr[11:8];
                    dig1 <= bcd_sr[7:4];
                    dig0 <= bcd_sr[3:0];
                    // A load arriving in this very cycle is newer than any pending one.
                    if (score_load || pend) begin
                        bin_sr     <= score_load ? score_clamped : pend_val;
                        bcd_sr     <= '0;
                        iter       <= '0;
                        pend       <= 1'b0;
                        conv_state <= CONV_SHIFT;
                    end else begin
                        busy       <= 1'b0;
                        conv_state <= CONV_IDLE;
                    end
                end
                default: conv_state <= CONV_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display / message FSM
    // ------------------------------------------------------------------
    typedef enum logic {SHOW_SCORE, SHOW_MSG} msg_state_t;

    msg_state_t    msg_state;
    logic [1:0]    cur_lvl;
    logic [1:0]    req_lvl;
    logic [3:0]    pos;
    logic [3:0]    pos_next;
    logic [TW-1:0] tick;
    logic [4:0]    lives_disp;

    assign req_lvl    = msg_req[2] ? LVL_GO : msg_req[1] ? LVL_LOSE : msg_req[0] ? LVL_WIN : 2'd0;
    assign pos_next   = (pos == msg_period(cur_lvl) - 4'd1) ? 4'd0 : pos + 4'd1;
    assign lives_disp = (lives > 4'd9) ? 5'd9 : {1'b0, lives};

    always_ff @(posedge clk) begin
        if (reset) begin
            msg_state  <= SHOW_SCORE;
            msg_active <= 1'b0;
            cur_lvl    <= 2'd0;
            pos        <= 4'd0;
            tick       <= '0;
            {hex5, hex4, hex3, hex2, hex1, hex0} <=
                {5'h00, C_DASH, score_digits(4'd0, 4'd0, 4'd0, 4'd0)};
        end else begin
            case (msg_state)
                SHOW_SCORE: begin
                    if (req_lvl != 2'd0) begin
                        msg_state  <= SHOW_MSG;
                        msg_active <= 1'b1;
                        cur_lvl    <= req_lvl;
                        pos        <= 4'd0;
                        tick       <= '0;
                        {hex5, hex4, hex3, hex2, hex1, hex0} <= msg_frame(req_lvl, 4'd0);
                    end else begin
                        {hex5, hex4, hex3, hex2, hex1, hex0} <=
                            {lives_disp, C_DASH, score_digits(dig3, dig2, dig1, dig0)};
                    end
                end
                SHOW_MSG: begin
                    if (req_lvl > cur_lvl) begin
                        cur_lvl <= req_lvl;
                        pos     <= 4'd0;
                        tick    <= '0;
                        {hex5, hex4, hex3, hex2, hex1, hex0} <= msg_frame(req_lvl, 4'd0);
                    end else if (msg_clear && (msg_req == 3'b000)) begin
                        // Any request in the same cycle, even an ignored one, masks the clear.
                        msg_state  <= SHOW_SCORE;
                        msg_active <= 1'b0;
                        {hex5, hex4, hex3, hex2, hex1, hex0} <=
                            {lives_disp, C_DASH, score_digits(dig3, dig2, dig1, dig0)};
                    end else if (tick == TW'(TICK_DIV - 1)) begin
                        tick <= '0;
                        pos  <= pos_next;
                        {hex5, hex4, hex3, hex2, hex1, hex0} <= msg_frame(cur_lvl, pos_next);
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: msg_state <= SHOW_SCORE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - self-checking bench for hex_display_ctrl
module tb_hex_display_ctrl;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] score;
    logic         score_load;
    logic [3:0]   lives;
    logic [2:0]   msg_req;
    logic         msg_clear;
    logic [4:0]   hex0, hex1, hex2, hex3, hex4, hex5;
    logic         msg_active;
    logic         busy;
    logic [29:0]  frame;

    always #5 clk = ~clk;

    assign frame = {hex5, hex4, hex3, hex2, hex1, hex0};

    hex_display_ctrl #(.SCORE_W(W), .TICK_DIV(2)) dut (
        .clk(clk), .reset(reset), .score(score), .score_load(score_load),
        .lives(lives), .msg_req(msg_req), .msg_clear(msg_clear),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .msg_active(msg_active), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [29:0] frame;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [W-1:0] score;
        logic [3:0]   lives;
        logic [3:0]   d5, d3, d2, d1, d0;
    } vec_t;
    vec_t vecs[8];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_sb();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk(e.name, {2'b00, frame}, {2'b00, e.frame});
        end
    endtask

    function automatic logic [29:0] pack6(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                                          input logic [4:0] d, input logic [4:0] e, input logic [4:0] f);
        return {a, b, c, d, e, f};
    endfunction

    function automatic logic [29:0] sframe(input logic [3:0] l, input logic [3:0] d3, input logic [3:0] d2,
                                           input logic [3:0] d1, input logic [3:0] d0);
        logic [4:0] c3, c2, c1;
        c3 = {1'b0, d3};
        c2 = {1'b0, d2};
        c1 = {1'b0, d1};
`ifdef HEX_LZB_EN
        if (d3 == 0) c3 = 5'h1E;
        if (d3 == 0 && d2 == 0) c2 = 5'h1E;
        if (d3 == 0 && d2 == 0 && d1 == 0) c1 = 5'h1E;
`endif
        return {1'b0, l, 5'h1F, c3, c2, c1, 1'b0, d0};
    endfunction

    // Virtual string character: sel 0=WIN, 1=LOSE, 2=GAME OVER.
    function automatic logic [4:0] vchar(input int sel, input int i);
        logic [4:0] c;
        c = 5'h1E;
        if (sel == 0) begin
            if (i == 0 || i == 1) c = 5'h1C;
            else if (i == 2) c = 5'h12;
            else if (i == 3) c = 5'h15;
        end else if (sel == 1) begin
            if (i == 0) c = 5'h13;
            else if (i == 1) c = 5'h16;
            else if (i == 2) c = 5'h1A;
            else if (i == 3) c = 5'h0E;
        end else begin
            case (i)
                0: c = 5'h10;
                1: c = 5'h0A;
                2: c = 5'h14;
                3: c = 5'h0E;
                5: c = 5'h16;
                6: c = 5'h1D;
                7: c = 5'h0E;
                8: c = 5'h19;
                default: c = 5'h1E;
            endcase
        end
        return c;
    endfunction

    function automatic logic [29:0] mframe(input int sel, input int p);
        logic [29:0] f;
        int per;
        per = (sel == 2) ? 15 : 10;
        f = '0;
        for (int k = 0; k < 6; k++) f = {f[24:0], vchar(sel, (p + k) % per)};
        return f;
    endfunction

    initial begin
        int busy_drop;
        int bad77;

        vecs[0] = '{14'd1234,  4'd3,  4'd3, 4'd1, 4'd2, 4'd3, 4'd4};
        vecs[1] = '{14'd12000, 4'd12, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        vecs[2] = '{14'd42,    4'd0,  4'd0, 4'd0, 4'd0, 4'd4, 4'd2};
        vecs[3] = '{14'd9999,  4'd9,  4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        vecs[4] = '{14'd0,     4'd15, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0};
        vecs[5] = '{14'd1000,  4'd5,  4'd5, 4'd1, 4'd0, 4'd0, 4'd0};
        vecs[6] = '{14'd16383, 4'd1,  4'd1, 4'd9, 4'd9, 4'd9, 4'd9};
        vecs[7] = '{14'd305,   4'd4,  4'd4, 4'd0, 4'd3, 4'd0, 4'd5};

        reset = 1'b1; score = '0; score_load = 1'b0; lives = 4'd3;
        msg_req = 3'b000; msg_clear = 1'b0;
        tick(2);
        chk("reset_frame", {2'b00, frame}, {2'b00, sframe(4'd0, 4'd0, 4'd0, 4'd0, 4'd0)});
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_msg_active", {31'd0, msg_active}, 32'd0);
        reset = 1'b0;
        tick(1);
        chk("lives_next_clock", {2'b00, frame}, {2'b00, sframe(4'd3, 4'd0, 4'd0, 4'd0, 4'd0)});

        // Score conversions: busy for W+1 cycles, digits W+2 cycles after load.
        for (int i = 0; i < 8; i++) begin
            lives = vecs[i].lives;
            score = vecs[i].score;
            score_load = 1'b1;
            sb.push_back('{$sformatf("score_vec%0d", i),
                           sframe(vecs[i].d5, vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0)});
            tick(1);
            score_load = 1'b0;
            chk($sformatf("busy_rise_vec%0d", i), {31'd0, busy}, 32'd1);
            tick(W);
            chk($sformatf("busy_last_vec%0d", i), {31'd0, busy}, 32'd1);
            tick(1);
            chk($sformatf("busy_fall_vec%0d", i), {31'd0, busy}, 32'd0);
            tick(1);
            chk_sb();
        end

        // Loads while busy: 5, then 77 and 88 back to back; 88 wins.
        lives = 4'd2;
        score = 14'd5; score_load = 1'b1;
        sb.push_back('{"pend_first_5", sframe(4'd2, 4'd0, 4'd0, 4'd0, 4'd5)});
        tick(1);
        score_load = 1'b0;
        tick(2);
        score = 14'd77; score_load = 1'b1;
        tick(1);
        score = 14'd88;
        tick(1);
        score_load = 1'b0;
        sb.push_back('{"pend_last_88", sframe(4'd2, 4'd0, 4'd0, 4'd8, 4'd8)});
        busy_drop = 0;
        bad77 = 0;
        for (int e = 5; e <= 32; e++) begin
            tick(1);
            if (e <= 29 && !busy) busy_drop++;
            if (frame == sframe(4'd2, 4'd0, 4'd0, 4'd7, 4'd7)) bad77++;
            if (e == 16) chk_sb();
            if (e == 30) chk("pend_busy_fall", {31'd0, busy}, 32'd0);
            if (e == 31) chk_sb();
        end
        chk("pend_busy_gaps", busy_drop, 0);
        chk("pend_77_frames", bad77, 0);

        // WIN scroll, TICK_DIV=2, period 10.
        msg_req = 3'b001;
        sb.push_back('{"win_frame0", pack6(5'h1C, 5'h1C, 5'h12, 5'h15, 5'h1E, 5'h1E)});
        tick(1);
        msg_req = 3'b000;
        chk_sb();
        chk("win_msg_active", {31'd0, msg_active}, 32'd1);
        tick(1);
        chk("win_hold", {2'b00, frame}, {2'b00, pack6(5'h1C, 5'h1C, 5'h12, 5'h15, 5'h1E, 5'h1E)});
        tick(1);
        chk("win_frame1", {2'b00, frame}, {2'b00, pack6(5'h1C, 5'h12, 5'h15, 5'h1E, 5'h1E, 5'h1E)});
        for (int s = 2; s <= 10; s++) begin
            sb.push_back('{$sformatf("win_step%0d", s), mframe(0, s % 10)});
            tick(2);
            chk_sb();
        end

        // Higher-priority GAME OVER replaces WIN; LOSE is then ignored.
        msg_req = 3'b100;
        tick(1);
        msg_req = 3'b000;
        chk("go_frame0", {2'b00, frame}, {2'b00, pack6(5'h10, 5'h0A, 5'h14, 5'h0E, 5'h1E, 5'h16)});
        tick(2);
        msg_req = 3'b010;
        tick(1);
        msg_req = 3'b000;
        chk("go_ignore_lose", {2'b00, frame}, {2'b00, pack6(5'h0A, 5'h14, 5'h0E, 5'h1E, 5'h16, 5'h1D)});
        // Request together with clear: clear ignored.
        msg_req = 3'b001; msg_clear = 1'b1;
        tick(1);
        msg_req = 3'b000; msg_clear = 1'b0;
        chk("req_beats_clear", {31'd0, msg_active}, 32'd1);
        chk("go_frame2", {2'b00, frame}, {2'b00, pack6(5'h14, 5'h0E, 5'h1E, 5'h16, 5'h1D, 5'h0E)});
        for (int s = 3; s <= 15; s++) begin
            sb.push_back('{$sformatf("go_step%0d", s), mframe(2, s % 15)});
            tick(2);
            chk_sb();
        end

        // Conversion in message mode stays hidden until the clear.
        lives = 4'd7;
        score = 14'd4321; score_load = 1'b1;
        tick(1);
        score_load = 1'b0;
        tick(W + 3);
        chk("conv_in_msg_active", {31'd0, msg_active}, 32'd1);
        msg_clear = 1'b1;
        tick(1);
        msg_clear = 1'b0;
        chk("clear_score_frame", {2'b00, frame}, {2'b00, sframe(4'd7, 4'd4, 4'd3, 4'd2, 4'd1)});
        chk("clear_msg_active", {31'd0, msg_active}, 32'd0);
        msg_clear = 1'b1;
        tick(1);
        msg_clear = 1'b0;
        chk("clear_in_score", {2'b00, frame}, {2'b00, sframe(4'd7, 4'd4, 4'd3, 4'd2, 4'd1)});

        // Reset mid-scroll and mid-conversion.
        msg_req = 3'b010;
        tick(1);
        msg_req = 3'b000;
        chk("lose_frame0", {2'b00, frame}, {2'b00, pack6(5'h13, 5'h16, 5'h1A, 5'h0E, 5'h1E, 5'h1E)});
        tick(3);
        score = 14'd999; score_load = 1'b1;
        tick(1);
        score_load = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("midrun_reset_frame", {2'b00, frame}, {2'b00, sframe(4'd0, 4'd0, 4'd0, 4'd0, 4'd0)});
        chk("midrun_reset_busy", {31'd0, busy}, 32'd0);
        chk("midrun_reset_msg", {31'd0, msg_active}, 32'd0);
        reset = 1'b0;
        tick(W + 4);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        chk("post_reset_frame", {2'b00, frame}, {2'b00, sframe(4'd7, 4'd0, 4'd0, 4'd0, 4'd0)});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
